// File: rtl/adc_pkg.sv
// Shared constants for the ADC frame controller: parameter defaults and FSM state encoding.
package adc_pkg;

  localparam int CLK_DIV_DEF = 4;
  localparam int NBITS_DEF   = 16;
  localparam int QUIET_DEF   = 2;

  typedef logic [2:0] adc_state_t;

  localparam adc_state_t ST_IDLE  = 3'd0;
  localparam adc_state_t ST_SETUP = 3'd1;
  localparam adc_state_t ST_SHIFT = 3'd2;
  localparam adc_state_t ST_HOLD  = 3'd3;
  localparam adc_state_t ST_GAP   = 3'd4;

  // Chip select is deasserted only while idle or in the inter-frame quiet gap.
  function automatic logic cs_high(input adc_state_t s);
    return (s == ST_IDLE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: one CLK_DIV-cycle sclk period per bit, low half first, idle high.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic en_next_i,
  output logic sclk_o,
  output logic period_end_o
);

  localparam int HALF = CLK_DIV / 2;
  localparam int PW   = $clog2(CLK_DIV);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          sclk_q, sclk_d;

  // The counter restarts at 0 on SHIFT entry, so sclk falls on the entry edge itself.
  always_comb begin
    pcnt_d = '0;
    if (en_next_i && en_i && (pcnt_q != PW'(CLK_DIV - 1))) begin
      pcnt_d = pcnt_q + 1'b1;
    end
    sclk_d = 1'b1;
    if (en_next_i) begin
      sclk_d = (pcnt_d >= PW'(HALF));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      sclk_q <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign period_end_o = en_i && (pcnt_q == PW'(CLK_DIV - 1));

endmodule

// File: rtl/adc.sv
// ADC frame controller: on a conversion request drives cs low and clocks NBITS sclk periods.
module adc
  import adc_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int NBITS   = NBITS_DEF,
  parameter int QUIET   = QUIET_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rvs,
  output logic       cs,
  output logic       sclk,
  output adc_state_t dbg_state_o
);

  localparam int HALF     = CLK_DIV / 2;
  localparam int WAIT_MAX = (HALF > QUIET) ? HALF : QUIET;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam int BW       = (NBITS > 1) ? $clog2(NBITS) : 1;

  generate
    if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
      $error("adc: CLK_DIV must be even and >= 2");
    end
    if (NBITS < 1) begin : g_bad_nbits
      $error("adc: NBITS must be >= 1");
    end
    if (QUIET < 1) begin : g_bad_quiet
      $error("adc: QUIET must be >= 1");
    end
  endgenerate

  adc_state_t    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          cs_q, cs_d;
  logic          period_end;
  logic          sclk_w;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (rvs) begin
          state_d = ST_SETUP;
          wait_d  = '0;
        end
      end
      ST_SETUP: begin
        if (wait_q == WW'(HALF - 1)) begin
          state_d = ST_SHIFT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (period_end) begin
          if (bit_q == BW'(NBITS - 1)) begin
            state_d = ST_HOLD;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (wait_q == WW'(HALF - 1)) begin
          state_d = ST_GAP;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (wait_q == WW'(QUIET - 1)) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
        bit_d   = '0;
      end
    endcase
    // cs is registered from the next state so it moves on the same edge as the FSM.
    cs_d = cs_high(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
    end
  end

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (state_q == ST_SHIFT),
    .en_next_i   (state_d == ST_SHIFT),
    .sclk_o      (sclk_w),
    .period_end_o(period_end)
  );

  assign cs          = cs_q;
  assign sclk        = sclk_w;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc.sv
// Directed bench for the ADC frame controller: default instance plus a CLK_DIV=2, NBITS=8 instance.
module tb_adc;
  import adc_pkg::*;

  localparam int DIV1 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rvs = 1'b0;
  logic       rvs2 = 1'b0;
  logic       cs, sclk, cs2, sclk2;
  adc_state_t st, st2;

  int total = 0;
  int bad   = 0;

  adc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rvs        (rvs),
    .cs         (cs),
    .sclk       (sclk),
    .dbg_state_o(st)
  );

  adc #(.CLK_DIV(2), .NBITS(8), .QUIET(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rvs        (rvs2),
    .cs         (cs2),
    .sclk       (sclk2),
    .dbg_state_o(st2)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // frame monitor on the default instance, sampled on the falling edge
  int   low_q[$], fall_q[$], first_q[$], spbad_q[$], gap_q[$];
  int   inv_bad = 0;
  bit   in_frame = 0, have_prev = 0;
  int   low_cnt, falls, first_fall, last_fall, spb, gap_cnt;
  logic pcs = 1'b1, psclk = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; have_prev = 0; gap_cnt = 0; pcs = 1'b1; psclk = 1'b1;
      end else begin
        if (pcs && cs && (psclk != sclk)) inv_bad++;
        if ((pcs != cs) && !(psclk && sclk)) inv_bad++;
        if (!cs) begin
          if (!in_frame) begin
            in_frame = 1; low_cnt = 0; falls = 0; first_fall = -1; last_fall = 0; spb = 0;
            if (have_prev) gap_q.push_back(gap_cnt);
          end
          low_cnt++;
          if (psclk && !sclk) begin
            if (falls == 0) first_fall = low_cnt - 1;
            else if (low_cnt - last_fall != DIV1) spb++;
            falls++;
            last_fall = low_cnt;
          end
        end else begin
          if (in_frame) begin
            low_q.push_back(low_cnt); fall_q.push_back(falls);
            first_q.push_back(first_fall); spbad_q.push_back(spb);
            in_frame = 0; have_prev = 1; gap_cnt = 0;
          end
          gap_cnt++;
        end
        pcs = cs; psclk = sclk;
      end
    end
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    low_q.delete(); fall_q.delete(); first_q.delete(); spbad_q.delete(); gap_q.delete();
  endtask

  task automatic do_reset();
    rvs = 1'b0; rvs2 = 1'b0; rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_q();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(cs && (st == ST_IDLE)) && (n < bound)) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", (cs && (st == ST_IDLE)), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int exp_low, input int exp_falls);
    chk({tag, "_frames"}, low_q.size(), 1);
    if (low_q.size() > 0) begin
      chk({tag, "_low"}, low_q.pop_front(), exp_low);
      chk({tag, "_falls"}, fall_q.pop_front(), exp_falls);
      chk({tag, "_first_fall"}, first_q.pop_front(), 2);
      chk({tag, "_spacing"}, spbad_q.pop_front(), 0);
    end
    clear_q();
  endtask

  typedef struct {
    logic rvs;
    logic cs;
    logic sclk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nb;
    // rvs applied before an edge; cs/sclk expected just after it
    vecs[0] = '{1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b1};

    // reset state with rvs high, then release with rvs low: stays idle
    rst_n = 1'b0; rvs = 1'b1;
    repeat (3) tick();
    chk("reset_cs", cs, 1);
    chk("reset_sclk", sclk, 1);
    chk("reset_state", st, ST_IDLE);
    chk("reset_cs2", cs2, 1);
    rvs = 1'b0;
    rst_n = 1'b1;
    nb = 0;
    repeat (20) begin
      tick();
      if ((cs !== 1'b1) || (sclk !== 1'b1)) nb++;
    end
    chk("idle_hold_bad_cycles", nb, 0);

    // rvs held through reset: frame starts on first post-reset edge
    rst_n = 1'b0; rvs = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("pre_edge_cs", cs, 1);
    tick();
    chk("post_reset_start_cs", cs, 0);
    chk("post_reset_start_state", st, ST_SETUP);
    rvs = 1'b0;
    wait_idle(200);
    check_frame("rst_start", 68, 16);

    // single pulse, cycle-by-cycle table for the frame start
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rvs = vecs[i].rvs;
      tick();
      chk($sformatf("vec%0d_cs", i), cs, vecs[i].cs);
      chk($sformatf("vec%0d_sclk", i), sclk, vecs[i].sclk);
    end
    rvs = 1'b0;
    wait_idle(200);
    check_frame("pulse", 68, 16);

    // pulses every 5 cycles: two frames, 7-cycle gap (next pulse after IDLE re-entry)
    do_reset();
    for (int j = 0; j < 30; j++) begin
      rvs = 1'b1;
      tick();
      rvs = 1'b0;
      repeat (4) tick();
    end
    wait_idle(200);
    chk("p5_frames", low_q.size(), 2);
    nb = 0;
    foreach (low_q[k]) if (low_q[k] != 68) nb++;
    chk("p5_low_bad", nb, 0);
    chk("p5_gaps", gap_q.size(), 1);
    if (gap_q.size() > 0) chk("p5_gap_len", gap_q[0], 7);
    clear_q();

    // rvs held for 300 cycles: five back-to-back frames with 3-cycle gaps
    do_reset();
    rvs = 1'b1;
    repeat (300) tick();
    rvs = 1'b0;
    wait_idle(200);
    chk("b2b_frames", low_q.size(), 5);
    nb = 0;
    foreach (low_q[k]) if ((low_q[k] != 68) || (fall_q[k] != 16)) nb++;
    chk("b2b_frame_bad", nb, 0);
    chk("b2b_gaps", gap_q.size(), 4);
    nb = 0;
    foreach (gap_q[k]) if (gap_q[k] != 3) nb++;
    chk("b2b_gap_bad", nb, 0);
    clear_q();

    // reset during bit 7 of SHIFT aborts at once; next frame is complete
    do_reset();
    rvs = 1'b1;
    tick();
    rvs = 1'b0;
    repeat (31) tick();
    chk("mid_state_shift", st, ST_SHIFT);
    chk("mid_sclk_low", sclk, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_sclk", sclk, 1);
    chk("abort_state", st, ST_IDLE);
    nb = 0;
    repeat (3) begin
      tick();
      if ((cs !== 1'b1) || (sclk !== 1'b1)) nb++;
    end
    chk("abort_hold_bad", nb, 0);
    rst_n = 1'b1;
    tick();
    clear_q();
    rvs = 1'b1;
    tick();
    rvs = 1'b0;
    wait_idle(200);
    check_frame("after_abort", 68, 16);

    // CLK_DIV=2, NBITS=8 instance
    begin
      int   low2, falls2, lastf2, spb2, n2;
      logic ps2;
      rvs2 = 1'b1;
      tick();
      rvs2 = 1'b0;
      low2 = 0; falls2 = 0; lastf2 = 0; spb2 = 0; n2 = 0; ps2 = 1'b1;
      while ((cs2 == 1'b0) && (n2 < 100)) begin
        low2++;
        if (ps2 && !sclk2) begin
          if ((falls2 > 0) && (low2 - lastf2 != 2)) spb2++;
          falls2++;
          lastf2 = low2;
        end
        ps2 = sclk2;
        tick();
        n2++;
      end
      chk("div2_low", low2, 18);
      chk("div2_falls", falls2, 8);
      chk("div2_spacing", spb2, 0);
      chk("div2_end_sclk", sclk2, 1);
    end

    chk("invariant_violations", inv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
